// File: rtl/math_pkg.sv
// Shared arithmetic-library package for the sequential integer math blocks.
// Provides the multiply-accumulate FSM state type and a helper that sizes
// the step counter so it can hold the value WIDTH itself.
package math_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } mul_state_t;

  // The counter has to reach WIDTH, not only WIDTH-1, so it needs
  // one more value than a plain bit index would.
  function automatic int mul_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/integer_shift_add.sv
// One combinational shift-and-add step of the unsigned multiplier.
// This is the mirror image of the divider's shift-subtract step.
// If lo_i[0] is set, the multiplicand is added into the accumulator.
// The (WIDTH+1)-bit sum, followed by lo_i[WIDTH-1:1], is then taken as
// the next {acc, lo} pair. That is a logical right shift in which the
// carry of the sum enters at the MSB.
//
// Ports:
//   acc_i  [WIDTH-1:0]  upper half of the partial product (accumulator)
//   lo_i   [WIDTH-1:0]  lower half (remaining multiplier bits / low product)
//   m_i    [WIDTH-1:0]  latched multiplicand
//   acc_o  [WIDTH-1:0]  next accumulator
//   lo_o   [WIDTH-1:0]  next lower half
module integer_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum   = {1'b0, acc_i} + (lo_i[0] ? {1'b0, m_i} : {(WIDTH+1){1'b0}});
    acc_o = sum[WIDTH:1];
    lo_o  = {sum[0], lo_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/integer_mul.sv
// Sequential unsigned multiply-accumulate:
//   product = multiplicand * multiplier + addend
// The block retires one multiplier bit per clock. It uses the same
// level-sensitive start/rdy handshake as the restoring divider.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   start         0 = load operands / idle, 1 = compute then hold result
//   multiplicand  [WIDTH-1:0]   operand A
//   multiplier    [WIDTH-1:0]   operand B
//   addend        [WIDTH-1:0]   accumulate term C
//   product       [2*WIDTH-1:0] A*B+C, meaningful only while rdy=1
//   rdy           registered result-valid flag
//
// state | meaning
// HOLD  | after reset; start=1 ignored until a low cycle loads operands
// LOAD  | operands latched every low cycle; first high edge begins iterating
// RUN   | one shift-add per high edge; low aborts back to LOAD
// DONE  | result held with rdy=1 while start stays high
module integer_mul
  import math_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   addend,
  output logic [2*WIDTH-1:0] product,
  output logic               rdy
);

  localparam int CW = mul_cnt_width(WIDTH);

  mul_state_t         state_q, state_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               rdy_q, rdy_d;

  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   lo_next;
  logic [CW-1:0]      cnt_inc;
  logic               last_step;
  logic               do_load;
  logic               do_step;

  integer_shift_add #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_i (p_q[2*WIDTH-1:WIDTH]),
    .lo_i  (p_q[WIDTH-1:0]),
    .m_i   (m_q),
    .acc_o (acc_next),
    .lo_o  (lo_next)
  );

  assign cnt_inc   = cnt_q + CW'(1);
  assign last_step = (cnt_inc == CW'(WIDTH));

  // A low start loads from every state. That includes HOLD, which is
  // the only way out of it. A high start iterates only in LOAD and RUN;
  // HOLD and DONE simply hold their registers.
  assign do_load = !start;
  assign do_step = start && ((state_q == LOAD) || (state_q == RUN));

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;

    if (do_load) begin
      state_d = LOAD;
      p_d     = {addend, multiplier};
      m_d     = multiplicand;
      cnt_d   = '0;
      rdy_d   = 1'b0;
    end else if (do_step) begin
      p_d   = {acc_next, lo_next};
      cnt_d = cnt_inc;
      if (last_step) begin
        state_d = DONE;
        rdy_d   = 1'b1;
      end else begin
        state_d = RUN;
        rdy_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      p_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  assign product = p_q;
  assign rdy     = rdy_q;

endmodule

// File: tb/tb_integer_mul.sv
module tb_integer_mul;

  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [W-1:0]     c;
  logic [2*W-1:0]   product;
  logic             rdy;

  int errors = 0;
  int checks = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] cur_exp = '0;
  logic           rdy_prev = 1'b0;

  integer_mul #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (a),
    .multiplier   (b),
    .addend       (c),
    .product      (product),
    .rdy          (rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: plain arithmetic on the operands presented at load.
  function automatic logic [2*W-1:0] ref_mac(input logic [W-1:0] x, y, z);
    longint r;
    r = longint'(x) * longint'(y) + longint'(z);
    return r[2*W-1:0];
  endfunction

  // Monitor: the rising edge of rdy delivers one result; while rdy stays
  // high the same value must keep being presented.
  always @(negedge clk) begin
    if (rdy && !rdy_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy: got rdy=1 product=%0d required no pending result (t=%0t)",
                 product, $time);
      end else begin
        cur_exp = exp_q.pop_front();
        chk("result", 64'(product), 64'(cur_exp));
      end
    end else if (rdy) begin
      chk("result_hold", 64'(product), 64'(cur_exp));
    end
    rdy_prev = rdy;
  end

  // One low (load) cycle, then n_high high cycles. rdy is checked after
  // every high edge. The expectation is queued only when the operation
  // is held long enough to complete.
  task automatic op(input logic [W-1:0] ia, ib, ic, input logic [2*W-1:0] ex,
                    input int n_high, input bit scramble, input string tag);
    @(posedge clk); #1;
    start = 1'b0;
    a = ia; b = ib; c = ic;
    @(posedge clk); #1;
    start = 1'b1;
    if (n_high >= W) exp_q.push_back(ex);
    if (scramble) begin
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
    end
    for (int i = 1; i <= n_high; i++) begin
      @(posedge clk); #1;
      chk({tag, "_rdy"}, 64'(rdy), 64'(i >= W));
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); c = W'($urandom);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dv, dd, q, r;
    logic [W-1:0] ra, rb, rc;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_product", 64'(product), 64'd0);
    chk("reset_rdy", 64'(rdy), 64'd0);
    rst = 1'b0;

    // Basic: rdy on the 8th high edge, then held 20 more cycles.
    op(8'd13, 8'd11, 8'd0, 16'd143, W + 20, 1'b0, "basic");

    // Maximum operands do not wrap.
    op(8'd255, 8'd255, 8'd255, 16'd65280, W + 2, 1'b0, "max");

    // Divider round trip: 200 / 7 -> q=28 r=4.
    op(8'd28, 8'd7, 8'd4, 16'd200, W, 1'b1, "div_200_7");
    for (int k = 0; k < 64; k++) begin
      dd = int'($urandom_range(1, 255));
      dv = int'($urandom_range(0, dd * 256 - 1));
      q  = dv / dd;
      r  = dv % dd;
      op(W'(q), W'(dd), W'(r), (2*W)'(dv), W + int'($urandom_range(0, 2)), 1'b1, "div_rt");
    end

    // Abort after 4 high edges, then a clean restart.
    op(W'($urandom), W'($urandom), W'($urandom), '0, 4, 1'b1, "abort");
    op(8'd3, 8'd5, 8'd1, 16'd16, W, 1'b0, "after_abort");

    // Reset mid-run with start held high; HOLD ignores start.
    op(8'd200, 8'd100, 8'd50, '0, 4, 1'b0, "pre_reset");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrun_reset_product", 64'(product), 64'd0);
    chk("midrun_reset_rdy", 64'(rdy), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_ignores_start", 64'(rdy), 64'd0);
    end
    op(8'd9, 8'd9, 8'd0, 16'd81, W + 1, 1'b0, "post_reset");

    // Random operands, scrambled inputs during RUN and DONE.
    for (int k = 0; k < 20; k++) begin
      ra = W'($urandom); rb = W'($urandom); rc = W'($urandom);
      op(ra, rb, rc, ref_mac(ra, rb, rc), W + int'($urandom_range(0, 3)), 1'b1, "rand");
    end

    // One-cycle start pulses never complete.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start = (i % 2 == 1);
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      @(posedge clk); #1;
      chk("pulse_no_rdy", 64'(rdy), 64'd0);
    end
    @(posedge clk); #1;
    start = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
